// File: rtl/lif_neuron_cluster.sv
`default_nettype none
// ============================================================================
//  Module      : lif_neuron_cluster
//  Description : Time-multiplexed cluster of leaky integrate-and-fire neurons
//                sharing one accumulate / decay / fire datapath. Input spike
//                events add per-neuron synaptic weights into current
//                registers; a time_step runs one decay/fire pass over all
//                neurons and publishes the resulting spike vector.
//  Revision    : 1.0  initial release
// ============================================================================
module lif_neuron_cluster #(
    parameter int N_NEURONS = 4,
    parameter int N_INPUTS  = 8,
    parameter int DATA_W    = 32,
    parameter int W_W       = 16,
    parameter int REF_W     = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_we,
    input  logic [1:0]                    cfg_sel,
    input  logic [$clog2(N_NEURONS)-1:0]  cfg_neuron,
    input  logic [$clog2(N_INPUTS)-1:0]   cfg_input,
    input  logic [DATA_W-1:0]             cfg_data,
    input  logic                          in_valid,
    input  logic [$clog2(N_INPUTS)-1:0]   in_addr,
    output logic                          in_ready,
    input  logic                          time_step,
    output logic                          busy,
    output logic [N_NEURONS-1:0]          spike_out,
    output logic                          spike_valid,
    output logic                          ts_overrun
);

    localparam int c_NW = $clog2(N_NEURONS);
    localparam int c_IW = $clog2(N_INPUTS);
    localparam logic [c_NW-1:0]          c_LAST  = c_NW'(N_NEURONS - 1);
    localparam logic signed [DATA_W-1:0] c_MAX   = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] c_MIN   = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [DATA_W+1:0] c_MAX_X = {2'b00, c_MAX};
    localparam logic signed [DATA_W+1:0] c_MIN_X = {2'b11, c_MIN};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_UPDATE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Per-neuron dynamic state
    logic signed [DATA_W-1:0] r_v     [N_NEURONS];
    logic signed [DATA_W-1:0] r_acc   [N_NEURONS];
    logic [REF_W-1:0]         r_ref   [N_NEURONS];

    // Per-neuron configuration
    logic signed [DATA_W-1:0] r_vt    [N_NEURONS];
    logic signed [DATA_W-1:0] r_vreset[N_NEURONS];
    logic [4:0]               r_shift [N_NEURONS];
    logic [REF_W-1:0]         r_rlen  [N_NEURONS];

    // Synaptic weight store, intentionally left uninitialised by reset
    logic [W_W-1:0]           r_weight[N_NEURONS][N_INPUTS];

    logic [c_NW-1:0]          r_idx;
    logic [c_IW-1:0]          r_addr;
    logic                     r_ts_pend;
    logic                     r_ts_overrun;
    logic [N_NEURONS-1:0]     r_bits;
    logic [N_NEURONS-1:0]     r_spike_out;
    logic                     r_spike_valid;

    // Shared datapath signals for the neuron selected by r_idx
    logic [W_W-1:0]           w_wt;
    logic signed [DATA_W-1:0] w_v_cur;
    logic signed [DATA_W-1:0] w_acc_cur;
    logic signed [DATA_W-1:0] w_leak;
    logic signed [DATA_W+1:0] w_acc_x;
    logic signed [DATA_W+1:0] w_vn_x;
    logic signed [DATA_W-1:0] w_acc_sum;
    logic signed [DATA_W-1:0] w_vn;
    logic                     w_fire;
    logic                     w_last;

    // Clamp a two-bit-extended result back into the signed DATA_W range
    function automatic logic signed [DATA_W-1:0] f_sat(input logic signed [DATA_W+1:0] x);
        if (x > c_MAX_X) begin
            return c_MAX;
        end else if (x < c_MIN_X) begin
            return c_MIN;
        end else begin
            return x[DATA_W-1:0];
        end
    endfunction

    assign in_ready    = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign spike_out   = r_spike_out;
    assign spike_valid = r_spike_valid;
    assign ts_overrun  = r_ts_overrun;
    assign w_last      = (r_idx == c_LAST);

    // Accumulate and leak/integrate arithmetic for the current neuron index
    always_comb begin
        w_wt      = r_weight[r_idx][r_addr];
        w_v_cur   = r_v[r_idx];
        w_acc_cur = r_acc[r_idx];
        w_leak    = (r_shift[r_idx] == 5'd0) ? '0 : (w_v_cur >>> r_shift[r_idx]);
        w_acc_x   = $signed({{2{w_acc_cur[DATA_W-1]}}, w_acc_cur})
                  + $signed({{(DATA_W+2-W_W){w_wt[W_W-1]}}, w_wt});
        w_vn_x    = $signed({{2{w_v_cur[DATA_W-1]}}, w_v_cur})
                  - $signed({{2{w_leak[DATA_W-1]}}, w_leak})
                  + $signed({{2{w_acc_cur[DATA_W-1]}}, w_acc_cur});
        w_acc_sum = f_sat(w_acc_x);
        w_vn      = f_sat(w_vn_x);
        w_fire    = (w_vn >= r_vt[r_idx]);
    end

    // Next-state selection; a time_step in the final ACCUM cycle still chains into UPDATE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = S_ACCUM;
                end else if (time_step) begin
                    w_state_nxt = S_UPDATE;
                end
            end
            S_ACCUM: begin
                if (w_last) begin
                    w_state_nxt = (r_ts_pend || time_step) ? S_UPDATE : S_IDLE;
                end
            end
            S_UPDATE: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Weight store writes, accepted only while idle
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && cfg_we && cfg_sel == 2'd0) begin
            r_weight[cfg_neuron][cfg_input] <= cfg_data[W_W-1:0];
        end
    end

    // State register, neuron sequencing, per-neuron state and configuration
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_addr        <= '0;
            r_ts_pend     <= 1'b0;
            r_ts_overrun  <= 1'b0;
            r_bits        <= '0;
            r_spike_out   <= '0;
            r_spike_valid <= 1'b0;
            for (int n = 0; n < N_NEURONS; n++) begin
                r_v[n]      <= '0;
                r_acc[n]    <= '0;
                r_ref[n]    <= '0;
                r_vt[n]     <= c_MAX;
                r_vreset[n] <= '0;
                r_shift[n]  <= '0;
                r_rlen[n]   <= '0;
            end
        end else begin
            r_state       <= w_state_nxt;
            r_spike_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_idx <= '0;
                    if (in_valid) begin
                        r_addr <= in_addr;
                        if (time_step) begin
                            r_ts_pend <= 1'b1;
                        end
                    end
                    if (cfg_we) begin
                        case (cfg_sel)
                            2'd1: r_vt[cfg_neuron]     <= cfg_data;
                            2'd2: r_vreset[cfg_neuron] <= cfg_data;
                            2'd3: begin
                                r_shift[cfg_neuron] <= cfg_data[4:0];
                                r_rlen[cfg_neuron]  <= cfg_data[REF_W+7:8];
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                S_ACCUM: begin
                    r_acc[r_idx] <= w_acc_sum;
                    if (time_step) begin
                        r_ts_pend <= 1'b1;
                    end
                    r_idx <= w_last ? '0 : r_idx + 1'b1;
                end
                S_UPDATE: begin
                    r_ts_pend <= 1'b0;
                    if (time_step) begin
                        r_ts_overrun <= 1'b1;
                    end
                    if (r_ref[r_idx] != '0) begin
                        r_ref[r_idx]  <= r_ref[r_idx] - REF_W'(1);
                        r_v[r_idx]    <= r_vreset[r_idx];
                        r_bits[r_idx] <= 1'b0;
                    end else if (w_fire) begin
                        r_v[r_idx]    <= r_vreset[r_idx];
                        r_ref[r_idx]  <= r_rlen[r_idx];
                        r_bits[r_idx] <= 1'b1;
                    end else begin
                        r_v[r_idx]    <= w_vn;
                        r_bits[r_idx] <= 1'b0;
                    end
                    r_acc[r_idx] <= '0;
                    r_idx <= w_last ? '0 : r_idx + 1'b1;
                end
                S_DONE: begin
                    if (time_step) begin
                        r_ts_overrun <= 1'b1;
                    end
                    r_spike_out   <= r_bits;
                    r_spike_valid <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
